// File: rtl/one_hot_encoder_pipe.sv
// one_hot_encoder_pipe: registered one-hot to binary encoder on a valid/ready stream with saturating error count.
// Optional ONE_HOT_ENC_SKID_EN adds a one-entry skid buffer so in_ready is registered.
module one_hot_encoder_pipe #(
  parameter int ONE_HOT_WIDTH = 4,
  parameter int BINARY_WIDTH  = $clog2(ONE_HOT_WIDTH),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ONE_HOT_WIDTH-1:0] one_hot_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BINARY_WIDTH-1:0]  binary_out,
  output logic                     out_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  input  logic                     err_clr
);
  logic [BINARY_WIDTH-1:0] enc_bin;
  logic                    enc_err;
  logic                    acc;
  always_comb begin
    enc_bin = '0;
    for (int i = ONE_HOT_WIDTH - 1; i >= 0; i--)
      if (one_hot_in[i]) enc_bin = BINARY_WIDTH'(i);
    enc_err = (one_hot_in == '0) || ((one_hot_in & (one_hot_in - ONE_HOT_WIDTH'(1))) != '0);
  end
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (err_clr) err_count <= '0;
    else if (acc && enc_err && err_count != '1) err_count <= err_count + 1'b1;
`ifdef ONE_HOT_ENC_SKID_EN
  logic                    skid_valid;
  logic [BINARY_WIDTH-1:0] skid_bin;
  logic                    skid_err;
  logic                    out_free;
  assign out_free = !out_valid || out_ready;
  assign in_ready = !skid_valid;
  // skid contents drain ahead of any new input so ordering is preserved
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      binary_out <= '0;
      out_error  <= 1'b0;
      skid_valid <= 1'b0;
      skid_bin   <= '0;
      skid_err   <= 1'b0;
    end else if (out_free) begin
      out_valid  <= skid_valid || acc;
      binary_out <= skid_valid ? skid_bin : acc ? enc_bin : '0;
      out_error  <= skid_valid ? skid_err : acc && enc_err;
      skid_valid <= 1'b0;
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_bin   <= enc_bin;
      skid_err   <= enc_err;
    end
`else
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      binary_out <= '0;
      out_error  <= 1'b0;
    end else if (acc) begin
      out_valid  <= 1'b1;
      binary_out <= enc_bin;
      out_error  <= enc_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      binary_out <= '0;
      out_error  <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_one_hot_encoder_pipe.sv
// tb_one_hot_encoder_pipe: directed stimulus with a queue-based reference model and cycle-by-cycle compare.
module tb_one_hot_encoder_pipe;
  localparam int ECW = 2;
  localparam int MAX = (1 << ECW) - 1;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_error, err_clr;
  logic [3:0] one_hot_in;
  logic [1:0] binary_out;
  logic [ECW-1:0] err_count;
  int total = 0, bad = 0;
  int qb[$], qe[$];
  int m_err = 0;
  bit acc_n, pop_n, clr_n;
  logic [3:0] w_n;

  one_hot_encoder_pipe #(.ONE_HOT_WIDTH(4), .ERR_CNT_WIDTH(ECW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .one_hot_in(one_hot_in), .out_valid(out_valid), .out_ready(out_ready),
    .binary_out(binary_out), .out_error(out_error), .err_count(err_count),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // trailing-zero count of the input; an all-zero word maps to index 0
  function automatic int model_bin(input logic [3:0] w);
    logic [3:0] lo;
    lo = w & (~w + 4'd1);
    return (w == 0) ? 0 : $countones(lo - 4'd1);
  endfunction

  function automatic int model_err(input logic [3:0] w);
    return ($countones(w) != 1) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    bit exp_rdy;
    if (!rst) begin
`ifdef ONE_HOT_ENC_SKID_EN
      exp_rdy = qb.size() < 2;
`else
      exp_rdy = (qb.size() == 0) || out_ready;
`endif
      chk("out_valid", int'(out_valid), int'(qb.size() > 0));
      if (qb.size() > 0) begin
        chk("binary_out", int'(binary_out), qb[0]);
        chk("out_error", int'(out_error), qe[0]);
      end
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("err_count", int'(err_count), m_err);
      acc_n = in_valid && exp_rdy;
      pop_n = (qb.size() > 0) && out_ready;
      clr_n = err_clr;
      w_n   = one_hot_in;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (pop_n) begin
        void'(qb.pop_front());
        void'(qe.pop_front());
      end
      if (acc_n) begin
        qb.push_back(model_bin(w_n));
        qe.push_back(model_err(w_n));
      end
      if (clr_n) m_err = 0;
      else if (acc_n && model_err(w_n) == 1 && m_err < MAX) m_err++;
    end
    acc_n = 0;
    pop_n = 0;
    clr_n = 0;
  end

  always @(posedge rst) begin
    qb.delete();
    qe.delete();
    m_err = 0;
    acc_n = 0;
    pop_n = 0;
    clr_n = 0;
  end

  task automatic send(input logic [3:0] w);
    bit acc;
    int n;
    one_hot_in = w;
    in_valid = 1;
    n = 0;
    do begin
      #1 acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] words [4];
    words = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    clk = 0; rst = 1; in_valid = 0; one_hot_in = 0; out_ready = 1; err_clr = 0;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_binary_out", int'(binary_out), 0);
    chk("rst_out_error", int'(out_error), 0);
    chk("rst_err_count", int'(err_count), 0);
    for (int i = 0; i < 4; i++) begin
      send(words[i]);
      chk("stream_bin", int'(binary_out), i);
      chk("stream_err", int'(out_error), 0);
    end
    idle();
    chk("stream_cnt", int'(err_count), 0);
    send(4'b0000);
    chk("zero_bin", int'(binary_out), 0);
    chk("zero_err", int'(out_error), 1);
    send(4'b0110);
    chk("multi_bin", int'(binary_out), 1);
    chk("multi_err", int'(out_error), 1);
    idle();
    chk("two_errs", int'(err_count), 2);
    err_clr = 1;
    idle();
    err_clr = 0;
    chk("clr_cnt", int'(err_count), 0);
    for (int i = 1; i <= 5; i++) begin
      send(4'b1010);
      chk("sat_cnt", int'(err_count), (i < 3) ? i : 3);
    end
    err_clr = 1;
    send(4'b0000);
    err_clr = 0;
    chk("clr_prio", int'(err_count), 0);
    chk("clr_prio_err", int'(out_error), 1);
    idle();
    send(4'b0100);
    out_ready = 0;
    one_hot_in = 4'b1000;
    in_valid = 1;
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("stall_hold", int'(binary_out), 2);
      chk("stall_valid", int'(out_valid), 1);
    end
`ifdef ONE_HOT_ENC_SKID_EN
    in_valid = 0;
`endif
    out_ready = 1;
    @(posedge clk);
    #2;
    in_valid = 0;
    chk("drain_bin", int'(binary_out), 3);
    chk("drain_valid", int'(out_valid), 1);
    idle();
    chk("drain_empty", int'(out_valid), 0);
    out_ready = 0;
    send(4'b0000);
    one_hot_in = 4'b0010;
    in_valid = 1;
    @(posedge clk);
    #2;
    in_valid = 0;
    chk("pre_rst_cnt", int'(err_count), 1);
    rst = 1;
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_cnt", int'(err_count), 0);
    @(posedge clk);
    #2 rst = 0;
    out_ready = 1;
    send(4'b0010);
    chk("post_rst_bin", int'(binary_out), 1);
    chk("post_rst_err", int'(out_error), 0);
    idle();
    chk("post_rst_empty", int'(out_valid), 0);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/one_hot_encoder_pipe.md
Name: one_hot_encoder_pipe

Overview:
- Registered one-hot-to-binary encoder; the inverse of the team's binary-to-one-hot decoder.
- Accepts one-hot words over a valid/ready stream and emits the binary index one cycle later, with a per-word error flag.
- Keeps a saturating count of malformed words.
- Sits between a one-hot grant/select source (arbiter, decoder output bus) and any binary-indexed consumer.

Parameters:
- ONE_HOT_WIDTH, 4, number of one-hot input bits; must be >= 2.
- BINARY_WIDTH, $clog2(ONE_HOT_WIDTH), number of binary output bits.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- one_hot_in  input  ONE_HOT_WIDTH  one-hot encoded input.
- out_valid  output  1  binary_out/out_error hold a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- binary_out  output  BINARY_WIDTH  binary index of the set bit.
- out_error  output  1  word was not exactly one-hot.
- err_count  output  ERR_CNT_WIDTH  saturating count of accepted malformed words.
- err_clr  input  1  synchronous clear of err_count.

Behaviour:
- Reset is asynchronous and active-high on rst; the single clock is clk. On assertion:
  - out_valid=0, binary_out=0, out_error=0, err_count=0.
  - Any skid entry is discarded.
  - In-flight words are dropped, not replayed.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid, binary_out and out_error hold stable while out_valid && !out_ready.
- Latency: an accepted word appears at the output on the next rising edge (1 cycle). Full throughput of 1 word/cycle when out_ready is held high.
- Base in_ready = !out_valid || out_ready (combinational).
- Encoding:
  - binary_out = index of the lowest set bit of one_hot_in.
  - Exactly one bit set: out_error=0.
  - Zero bits set: binary_out=0, out_error=1.
  - Two or more bits set: binary_out = lowest set index, out_error=1.
- Error counter:
  - Increments by 1 on each accepted input word that is not exactly one-hot.
  - Saturates at 2^ERR_CNT_WIDTH-1; no wrap.
  - err_clr=1 sets err_count to 0 on the next edge. err_clr takes priority over a simultaneous increment, so the result is 0.
- Input accepted and output consumed in the same cycle: the register loads the new word and out_valid stays 1.
- Input on one_hot_in while in_ready=0 is ignored and not counted.
- X-free: binary_out never depends on one_hot_in bits when out_valid=0.

Optional Feature:
- Macro: ONE_HOT_ENC_SKID_EN.
- Defined:
  - A one-entry skid buffer is added behind the output register.
  - in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - When the output stalls and a word is accepted, the word goes to skid.
  - When the output drains, the skid word moves to the output register on the next edge. Skid data has priority over new input.
  - No-stall latency stays 1 cycle; throughput stays 1 word/cycle.
  - Words are counted for err_count at input acceptance.
  - Reset clears skid_valid.
- Not defined: no skid; in_ready is the combinational expression above.

Test Plan:
- Reset then stream 0001,0010,0100,1000 with out_ready=1 -> binary_out 0,1,2,3 one cycle after each accept; out_error=0; err_count=0.
- Send 0000 then 0110 -> (binary_out=0, out_error=1), then (binary_out=1, out_error=1); err_count=2.
- Hold out_ready=0 after accepting 0100 and present 1000 -> output stable at 2. Without the macro, in_ready=0 and 1000 is not accepted until out_ready=1. With ONE_HOT_ENC_SKID_EN, 1000 is held in skid, and after out_ready=1 the outputs are 2 then 3 with no loss or duplication.
- With ERR_CNT_WIDTH=2, send 5 malformed words -> err_count reads 1,2,3,3,3. Then assert err_clr on the same cycle as another malformed accept -> err_count=0.
- Assert rst mid-stream while out_valid=1 and the skid is occupied -> out_valid=0, err_count=0 immediately (asynchronously). After release, the first new word 0010 yields binary_out=1 with no stale output.
